// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - op_e    : 3-bit operation code presented on muldiv_ctrl.op
//   - state_e : control FSM state encoding
//   - DIV_ITER: number of radix-2 restoring divide iterations
//   - abs32   : magnitude of a 32-bit operand, optionally treated as signed
package muldiv_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Magnitude of v; only negated when the operation is signed and v is negative.
    // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// div_iter: iterative radix-2 restoring divider on unsigned magnitudes.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : load dividend/divisor and begin DIV_ITER iterations
//   abort         : abandon a running division
//   dividend      : 32-bit unsigned dividend magnitude (sampled on start)
//   divisor       : 32-bit unsigned divisor magnitude, nonzero (sampled on start)
//   done          : high during the cycle whose clock edge performs the last iteration
//   quot_next     : quotient after the iteration performed this cycle
//   rem_next      : remainder after the iteration performed this cycle
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot_next,
    output logic [31:0] rem_next
);

    localparam logic [5:0] LAST_CNT = 6'(DIV_ITER - 1);

    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic [5:0]  cnt_q;
    logic        run_q;

    logic [32:0] shifted_s;
    logic [32:0] trial_s;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    assign shifted_s = {rem_q, quot_q[31]};
    assign trial_s   = shifted_s - {1'b0, dvsr_q};
    assign rem_next  = trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
    assign quot_next = {quot_q[30:0], ~trial_s[32]};
    assign done      = run_q && (cnt_q == LAST_CNT);

    // Operand load, one iteration per cycle while running, stop after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            dvsr_q <= 32'd0;
            cnt_q  <= 6'd0;
            run_q  <= 1'b0;
        end else if (abort) begin
            cnt_q  <= 6'd0;
            run_q  <= 1'b0;
        end else if (start) begin
            quot_q <= dividend;
            rem_q  <= 32'd0;
            dvsr_q <= divisor;
            cnt_q  <= 6'd0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            quot_q <= quot_next;
            rem_q  <= rem_next;
            if (done) begin
                cnt_q <= 6'd0;
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide/move unit of a MIPS-style EX stage.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   op_valid, op       : HI/LO-class instruction present in EX and its op code
//   src_a, src_b       : rs / rt operand values
//   flush              : cancel the in-flight operation
//   hi_cur, lo_cur     : current HI/LO contents (for the half not written by MTHI/MTLO)
//   busy               : stall request while a multi-cycle op occupies the unit
//   hilo_we            : one-cycle HI/LO write enable
//   hi_wdata, lo_wdata : registered values written to HI/LO
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        we_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_mul_s;
    logic        is_div_s;
    logic        is_signed_s;
    logic        op_known_s;
    logic        div_zero_s;
    logic        accept_s;
    logic        div_start_s;
    logic        div_done_s;
    logic [31:0] quot_nx_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;

    assign is_mul_s    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_s    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed_s = (op == OP_MULT) || (op == OP_DIV);
    assign op_known_s  = is_mul_s || is_div_s || (op == OP_MTHI) || (op == OP_MTLO);
    assign div_zero_s  = (src_b == 32'd0);
    assign accept_s    = (state_q == ST_IDLE) && op_valid && !flush && op_known_s;
    assign div_start_s = accept_s && is_div_s && !div_zero_s;

    // Stall is requested already in the accepting cycle so EX holds the instruction;
    // divide-by-zero completes in one cycle and never stalls.
    assign busy = !rst && !flush &&
                  ((state_q == ST_MUL) || (state_q == ST_DIV) ||
                   ((state_q == ST_IDLE) && op_valid &&
                    (is_mul_s || (is_div_s && !div_zero_s))));

    // Sign-extending (or zero-extending) to 64 bits makes the low 64 bits of a
    // plain multiply the correct signed or unsigned product.
    assign mul_a_s = {{32{sgn_q & a_q[31]}}, a_q};
    assign mul_b_s = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod_s  = mul_a_s * mul_b_s;

    assign quot_fix_s = neg_quo_q ? (32'd0 - quot_nx_s) : quot_nx_s;
    assign rem_fix_s  = neg_rem_q ? (32'd0 - rem_nx_s)  : rem_nx_s;

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .abort     (flush),
        .dividend  (abs32(src_a, is_signed_s)),
        .divisor   (abs32(src_b, is_signed_s)),
        .done      (div_done_s),
        .quot_next (quot_nx_s),
        .rem_next  (rem_nx_s)
    );

    // Control FSM with registered HI/LO write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            we_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_q       <= src_a;
                        b_q       <= src_b;
                        sgn_q     <= is_signed_s;
                        neg_quo_q <= is_signed_s && (src_a[31] ^ src_b[31]);
                        neg_rem_q <= is_signed_s && src_a[31];
                        case (op)
                            OP_MULT, OP_MULTU: state_q <= ST_MUL;
                            OP_DIV, OP_DIVU: begin
                                if (div_zero_s) begin
                                    hi_q    <= src_a;
                                    lo_q    <= 32'hFFFF_FFFF;
                                    we_q    <= 1'b1;
                                    state_q <= ST_WB;
                                end else begin
                                    state_q <= ST_DIV;
                                end
                            end
                            OP_MTHI: begin
                                hi_q    <= src_a;
                                lo_q    <= lo_cur;
                                we_q    <= 1'b1;
                                state_q <= ST_WB;
                            end
                            OP_MTLO: begin
                                hi_q    <= hi_cur;
                                lo_q    <= src_a;
                                we_q    <= 1'b1;
                                state_q <= ST_WB;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q    <= prod_s[63:32];
                        lo_q    <= prod_s[31:0];
                        we_q    <= 1'b1;
                        state_q <= ST_WB;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (div_done_s) begin
                        hi_q    <= rem_fix_s;
                        lo_q    <= quot_fix_s;
                        we_q    <= 1'b1;
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
                ST_WB:   state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A flush arriving during WB still cancels the write.
    assign hilo_we  = we_q && !flush;
    assign hi_wdata = hi_q;
    assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .hi_cur   (hi_cur),
        .lo_cur   (lo_cur),
        .busy     (busy),
        .hilo_we  (hilo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        return e;
    endfunction

    // Reference model built on the simulator's own 64-bit arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hc, input logic [31:0] lc);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] u;
        exp_t        e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (o)
            MULT:  begin sq = sa * sb; u = sq; e.hi = u[63:32]; e.lo = u[31:0]; end
            MULTU: begin u = {32'd0, a} * {32'd0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
            DIV: begin
                if (b == 32'd0) e = mk(a, 32'hFFFF_FFFF);
                else begin sq = sa / sb; sr = sa % sb; e.lo = sq[31:0]; e.hi = sr[31:0]; end
            end
            DIVU: begin
                if (b == 32'd0) e = mk(a, 32'hFFFF_FFFF);
                else begin e.lo = a / b; e.hi = a % b; end
            end
            MTHI:    e = mk(a, lc);
            MTLO:    e = mk(hc, a);
            default: e = '0;
        endcase
        return e;
    endfunction

    // Present one op for one cycle (caller is just after a rising edge), sample busy
    // in the accepting cycle, then scramble the operands to expose missing latching.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic busy_acc);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        busy_acc = busy;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h0BAD_F00D;
    endtask

    // Wait (bounded) for the write pulse; lat counts cycles from acceptance.
    task automatic wait_write(input int limit, output int lat, output int busy_cyc,
                              output logic busy_wb, output logic [31:0] hi, output logic [31:0] lo);
        bit seen;
        seen     = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        busy_wb  = 1'bx;
        hi       = 'x;
        lo       = 'x;
        while (!seen && lat <= limit) begin
            @(negedge clk);
            if (hilo_we) begin
                seen    = 1'b1;
                hi      = hi_wdata;
                lo      = lo_wdata;
                busy_wb = busy;
            end else begin
                if (busy) busy_cyc++;
                @(posedge clk);
                #1;
                lat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_writes(input int n, output int w);
        w = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hilo_we) w++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; hi_cur = 32'd0; lo_cur = 32'd0;
        op_valid = 1'b1; op = MULT; src_a = 32'd5; src_b = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b want 0", busy); end
        tests_run++; if (hilo_we !== 1'b0) begin tests_failed++; $display("FAIL reset hilo_we: got %b want 0", hilo_we); end
        tests_run++; if (hi_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset hi_wdata: got %h want 0", hi_wdata); end
        tests_run++; if (lo_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset lo_wdata: got %h want 0", lo_wdata); end
        op_valid = 1'b0; op = NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Multiply and divide vectors; busy covers the accepting cycle and every cycle before WB.
    task automatic test_arith;
        logic [2:0]  vop [5];
        logic [31:0] va  [5];
        logic [31:0] vb  [5];
        logic [31:0] vhi [5];
        logic [31:0] vlo [5];
        int          vlat[5];
        logic busy_acc, busy_wb;
        int lat, bc;
        logic [31:0] hi, lo;
        exp_t e;
        vop[0]=MULT;  va[0]=32'hFFFF_FFFE; vb[0]=32'd3;         vhi[0]=32'hFFFF_FFFF; vlo[0]=32'hFFFF_FFFA; vlat[0]=2;
        vop[1]=DIVU;  va[1]=32'd100;       vb[1]=32'd7;         vhi[1]=32'd2;         vlo[1]=32'd14;        vlat[1]=33;
        vop[2]=DIV;   va[2]=32'hFFFF_FFF9; vb[2]=32'd2;         vhi[2]=32'hFFFF_FFFF; vlo[2]=32'hFFFF_FFFD; vlat[2]=33;
        vop[3]=DIV;   va[3]=32'h8000_0000; vb[3]=32'hFFFF_FFFF; vhi[3]=32'd0;         vlo[3]=32'h8000_0000; vlat[3]=33;
        vop[4]=MULTU; va[4]=32'hFFFF_FFFF; vb[4]=32'hFFFF_FFFF; vhi[4]=32'hFFFF_FFFE; vlo[4]=32'd1;         vlat[4]=2;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(mk(vhi[i], vlo[i]));
            issue(vop[i], va[i], vb[i], busy_acc);
            wait_write(40, lat, bc, busy_wb, hi, lo);
            e = sb_q.pop_front();
            tests_run++; if (busy_acc !== 1'b1) begin tests_failed++; $display("FAIL arith%0d busy_accept: got %b want 1", i, busy_acc); end
            tests_run++; if (lat != vlat[i]) begin tests_failed++; $display("FAIL arith%0d latency: got %0d want %0d", i, lat, vlat[i]); end
            tests_run++; if (bc != vlat[i] - 1) begin tests_failed++; $display("FAIL arith%0d busy_cycles: got %0d want %0d", i, bc, vlat[i] - 1); end
            tests_run++; if (busy_wb !== 1'b0) begin tests_failed++; $display("FAIL arith%0d busy_wb: got %b want 0", i, busy_wb); end
            tests_run++; if (hi !== e.hi) begin tests_failed++; $display("FAIL arith%0d hi: got %h want %h", i, hi, e.hi); end
            tests_run++; if (lo !== e.lo) begin tests_failed++; $display("FAIL arith%0d lo: got %h want %h", i, lo, e.lo); end
        end
    endtask

    task automatic test_move;
        logic [2:0]  mop [2];
        logic [31:0] ma  [2];
        logic busy_acc, busy_wb;
        int lat, bc;
        logic [31:0] hi, lo;
        exp_t e;
        mop[0] = MTLO; ma[0] = 32'h1234_5678;
        mop[1] = MTHI; ma[1] = 32'hCAFE_BABE;
        hi_cur = 32'hAAAA_0000;
        lo_cur = 32'h5555_1111;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(model(mop[i], ma[i], 32'd0, hi_cur, lo_cur));
            issue(mop[i], ma[i], 32'd0, busy_acc);
            wait_write(5, lat, bc, busy_wb, hi, lo);
            e = sb_q.pop_front();
            tests_run++; if (busy_acc !== 1'b0 || bc != 0 || busy_wb !== 1'b0) begin tests_failed++; $display("FAIL move%0d busy: got acc=%b cyc=%0d wb=%b want all 0", i, busy_acc, bc, busy_wb); end
            tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL move%0d latency: got %0d want 1", i, lat); end
            tests_run++; if (hi !== e.hi) begin tests_failed++; $display("FAIL move%0d hi: got %h want %h", i, hi, e.hi); end
            tests_run++; if (lo !== e.lo) begin tests_failed++; $display("FAIL move%0d lo: got %h want %h", i, lo, e.lo); end
        end
    endtask

    // A second op offered while the multiplier is busy must be dropped.
    task automatic test_ignore_busy;
        logic busy_acc, busy_wb;
        int lat, bc, w;
        logic [31:0] hi, lo;
        exp_t e;
        sb_q.push_back(mk(32'd0, 32'd42));
        issue(MULTU, 32'd6, 32'd7, busy_acc);
        op_valid = 1'b1; op = MTHI; src_a = 32'h7777_7777;
        @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ignore busy_mul: got %b want 1", busy); end
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP;
        wait_write(3, lat, bc, busy_wb, hi, lo);
        e = sb_q.pop_front();
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL ignore wb_timing: got %0d want 1", lat); end
        tests_run++; if (hi !== e.hi || lo !== e.lo) begin tests_failed++; $display("FAIL ignore result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
        count_writes(5, w);
        tests_run++; if (w != 0) begin tests_failed++; $display("FAIL ignore extra_writes: got %0d want 0", w); end
    endtask

    task automatic test_flush;
        logic busy_acc, busy_wb;
        int lat, bc, w;
        logic [31:0] hi, lo;
        exp_t e;
        issue(DIVU, 32'd1000, 32'd3, busy_acc);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush busy: got %b want 0", busy); end
        tests_run++; if (hilo_we !== 1'b0) begin tests_failed++; $display("FAIL flush hilo_we: got %b want 0", hilo_we); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb_q.push_back(model(MULTU, 32'd5, 32'd5, hi_cur, lo_cur));
        issue(MULTU, 32'd5, 32'd5, busy_acc);
        wait_write(5, lat, bc, busy_wb, hi, lo);
        e = sb_q.pop_front();
        tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL flush mul_latency: got %0d want 2", lat); end
        tests_run++; if (hi !== e.hi || lo !== e.lo) begin tests_failed++; $display("FAIL flush mul_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
        count_writes(30, w);
        tests_run++; if (w != 0) begin tests_failed++; $display("FAIL flush stale_writes: got %0d want 0", w); end
    endtask

    task automatic test_reset_mid;
        logic busy_acc, busy_wb;
        int lat, bc, w;
        logic [31:0] hi, lo;
        exp_t e;
        issue(DIV, 32'd1000, 32'd3, busy_acc);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mid ctrl: got busy=%b we=%b want 0 0", busy, hilo_we); end
        tests_run++; if (hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin tests_failed++; $display("FAIL rst_mid data: got %h_%h want 0_0", hi_wdata, lo_wdata); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        count_writes(20, w);
        tests_run++; if (w != 0) begin tests_failed++; $display("FAIL rst_mid stale_writes: got %0d want 0", w); end
        sb_q.push_back(mk(32'd9, 32'hFFFF_FFFF));
        issue(DIV, 32'd9, 32'd0, busy_acc);
        wait_write(5, lat, bc, busy_wb, hi, lo);
        e = sb_q.pop_front();
        tests_run++; if (busy_acc !== 1'b0) begin tests_failed++; $display("FAIL divzero busy: got %b want 0", busy_acc); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL divzero latency: got %0d want 1", lat); end
        tests_run++; if (hi !== e.hi || lo !== e.lo) begin tests_failed++; $display("FAIL divzero result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
    endtask

    // Random ops issued the cycle after each WB, checked against the model.
    task automatic test_back_to_back;
        logic [2:0] ops [6];
        logic [2:0] o;
        logic [31:0] a, b;
        logic busy_acc, busy_wb;
        int lat, bc, elat;
        logic [31:0] hi, lo;
        exp_t e;
        ops[0] = MULT; ops[1] = MULTU; ops[2] = DIV; ops[3] = DIVU; ops[4] = MTHI; ops[5] = MTLO;
        for (int i = 0; i < 10; i++) begin
            o      = ops[$urandom_range(0, 5)];
            a      = $urandom();
            b      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            hi_cur = $urandom();
            lo_cur = $urandom();
            if (o == MULT || o == MULTU) elat = 2;
            else if ((o == DIV || o == DIVU) && b != 32'd0) elat = 33;
            else elat = 1;
            sb_q.push_back(model(o, a, b, hi_cur, lo_cur));
            issue(o, a, b, busy_acc);
            wait_write(40, lat, bc, busy_wb, hi, lo);
            e = sb_q.pop_front();
            tests_run++; if (busy_acc !== (elat > 1)) begin tests_failed++; $display("FAIL b2b%0d busy_accept: got %b want %b", i, busy_acc, elat > 1); end
            tests_run++; if (lat != elat) begin tests_failed++; $display("FAIL b2b%0d latency op=%0d: got %0d want %0d", i, o, lat, elat); end
            tests_run++; if (hi !== e.hi || lo !== e.lo) begin tests_failed++; $display("FAIL b2b%0d result op=%0d a=%h b=%h: got %h_%h want %h_%h", i, o, a, b, hi, lo, e.hi, e.lo); end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_move();
        test_ignore_busy();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
